// File: rtl/dram_ctrl.sv
// dram_ctrl: L2 request FIFO feeding a bit-serial DRAM bank array through a 4-phase cmd_req/cmd_ack handshake.
// Latency: push->pop 1 cycle, pop->ACT 2 cycles, then 8 serial data cycles plus one handshake per command.
// Backpressure: none toward L2 (pushes into a full FIFO are dropped); each DRAM command waits on cmd_ack indefinitely.
// Optional DRAM_CTRL_OPEN_PAGE_EN: keep the row open between requests, close it with PRE on a row miss or when idle.

module dram_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [W-1:0]  rd_dat_q, rd_dat_d;
  logic          do_wr, do_rd;

  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign rd_dat = rd_dat_q;
  assign do_wr  = wr_en && !full;
  assign do_rd  = rd_en && !empty;

  // pointer/count bookkeeping; read data is registered on pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    rd_dat_d = rd_dat_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rd_dat_d = mem_q[rd_ptr_q];
    end
    if (do_wr && !do_rd) cnt_d = cnt_q + 1'b1;
    if (!do_wr && do_rd) cnt_d = cnt_q - 1'b1;
  end

  // control state, cleared by reset so contents are discarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rd_dat_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rd_dat_q <= rd_dat_d;
    end
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end
endmodule

module dram_ctrl #(
  parameter int L2_REQ_WIDTH   = 22,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_OF_BANKS   = 8,
  parameter int NUM_OF_ROWS    = 128,
  parameter int NUM_OF_COLS    = 8,
  parameter int CONCAT_ADDRESS = 20,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic                    l2_rw_req,
  input  logic [L2_REQ_WIDTH-1:0] l2_req_instr,
  input  logic [DATA_WIDTH-1:0]   l2_req_data,
  input  logic                    cmd_ack,
  inout  wire                     dram_data,
  output logic                    cmd_req,
  output logic [1:0]              cmd,
  output logic [NUM_OF_BANKS-1:0] bank_sel,
  output logic [NUM_OF_ROWS-1:0]  row_sel,
  output logic [NUM_OF_COLS-1:0]  col_sel,
  output logic [DATA_WIDTH-1:0]   l2_rsp_data,
  output logic                    bank_rw,
  output logic                    buf_rw
);
  localparam int ENT_W  = 1 + CONCAT_ADDRESS + DATA_WIDTH;
  localparam int BANK_W = $clog2(NUM_OF_BANKS);
  localparam int ROW_W  = $clog2(NUM_OF_ROWS);
  localparam int COL_W  = $clog2(NUM_OF_COLS);
  localparam int BANK_LSB = DATA_WIDTH + 10;
  localparam int ROW_LSB  = DATA_WIDTH + 3;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_OF_COLS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_ACT   = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_RD    = 3'd5;
  localparam logic [2:0] ST_DRAIN = 3'd6;
  localparam logic [2:0] ST_PRE   = 3'd7;

  localparam logic [1:0] CMD_ACT = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;
  localparam logic [1:0] CMD_PRE = 2'b11;

  // handshake phase: 1 = cmd_req high awaiting ack, 2 = cmd_req low awaiting ack release
  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_REQ  = 2'd1;
  localparam logic [1:0] PH_REL  = 2'd2;

  logic [ENT_W-1:0]        fifo_rd_dat;
  logic                    fifo_rd_en, fifo_full, fifo_empty, fifo_wr_en;
  logic [2:0]              state_q, state_d;
  logic [1:0]              phase_q, phase_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [ENT_W-1:0]        buf_out_q, buf_out_d;
  logic [DATA_WIDTH-1:0]   rd_shift_q, rd_shift_d, rsp_q, rsp_d, wr_byte;
  logic                    cmd_req_q, cmd_req_d, bank_rw_q, bank_rw_d, buf_rw_q, buf_rw_d;
  logic                    drv_en_q, drv_en_d, dout_q, dout_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [NUM_OF_BANKS-1:0] bank_sel_q, bank_sel_d;
  logic [NUM_OF_ROWS-1:0]  row_sel_q, row_sel_d;
  logic [NUM_OF_COLS-1:0]  col_sel_q, col_sel_d;
  logic [BANK_W-1:0]       ld_bank;
  logic [ROW_W-1:0]        ld_row;
  logic                    load_ids, hs_done, unused_bits;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
  logic                    open_q, open_d, pend_act_q, pend_act_d, row_hit;
`endif

  assign fifo_wr_en = l2_req_instr[L2_REQ_WIDTH-1];

  dram_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) l2_req_buffer (
    .clk    (clk),
    .rst    (rst_b),
    .wr_en  (fifo_wr_en),
    .wr_dat ({l2_rw_req, l2_req_instr[CONCAT_ADDRESS-1:0], l2_req_data}),
    .rd_en  (fifo_rd_en),
    .rd_dat (fifo_rd_dat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // ids come straight from the FIFO while latching, else from the held entry
  assign ld_bank = (state_q == ST_LATCH) ? fifo_rd_dat[BANK_LSB +: BANK_W] : buf_out_q[BANK_LSB +: BANK_W];
  assign ld_row  = (state_q == ST_LATCH) ? fifo_rd_dat[ROW_LSB +: ROW_W]   : buf_out_q[ROW_LSB +: ROW_W];
  assign hs_done = (phase_q == PH_REL) && !cmd_ack;
  assign unused_bits = ^{l2_req_instr[L2_REQ_WIDTH-2:CONCAT_ADDRESS], buf_out_q[DATA_WIDTH+13 +: 7],
                         buf_out_q[DATA_WIDTH +: 3], fifo_full};
`ifdef DRAM_CTRL_OPEN_PAGE_EN
  assign row_hit = (bank_sel_q == (NUM_OF_BANKS'(1) << ld_bank)) && (row_sel_q == (NUM_OF_ROWS'(1) << ld_row));
`endif

  function automatic logic is_cmd(input logic [2:0] s);
    return (s == ST_ACT) || (s == ST_WR) || (s == ST_RD) || (s == ST_PRE);
  endfunction

  // request sequencing: pop, latch, ACT, data transfer, PRE
  always_comb begin
    fifo_rd_en = 1'b0;
    state_d    = state_q;
    phase_d    = phase_q;
    col_d      = col_q;
    buf_out_d  = buf_out_q;
    rd_shift_d = rd_shift_q;
    rsp_d      = rsp_q;
    load_ids   = 1'b0;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
    open_d     = open_q;
    pend_act_d = pend_act_q;
`endif
    if (phase_q == PH_REQ && cmd_ack) phase_d = PH_REL;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = ST_LATCH;
        end
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        else if (open_q) state_d = ST_PRE;
`endif
      end
      ST_LATCH: begin
        buf_out_d = fifo_rd_dat;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
        if (open_q && row_hit) state_d = fifo_rd_dat[ENT_W-1] ? ST_FILL : ST_RD;
        else if (open_q) begin
          state_d    = ST_PRE;
          pend_act_d = 1'b1;
        end else begin
          state_d  = ST_ACT;
          load_ids = 1'b1;
        end
`else
        state_d  = ST_ACT;
        load_ids = 1'b1;
`endif
      end
      ST_ACT: if (hs_done) state_d = buf_out_q[ENT_W-1] ? ST_FILL : ST_RD;
      ST_FILL: begin
        if (col_q == COL_LAST) state_d = ST_WR;
        else col_d = col_q + 1'b1;
      end
      ST_WR: begin
        if (hs_done) begin
`ifdef DRAM_CTRL_OPEN_PAGE_EN
          state_d = ST_IDLE;
          open_d  = 1'b1;
`else
          state_d = ST_PRE;
`endif
        end
      end
      ST_RD: if (hs_done) state_d = ST_DRAIN;
      ST_DRAIN: begin
        rd_shift_d[col_q] = dram_data;
        if (col_q == COL_LAST) begin
          rsp_d = {dram_data, rd_shift_q[DATA_WIDTH-2:0]};
`ifdef DRAM_CTRL_OPEN_PAGE_EN
          state_d = ST_IDLE;
          open_d  = 1'b1;
`else
          state_d = ST_PRE;
`endif
        end else col_d = col_q + 1'b1;
      end
      ST_PRE: begin
        if (hs_done) begin
`ifdef DRAM_CTRL_OPEN_PAGE_EN
          open_d = 1'b0;
          if (pend_act_q) begin
            pend_act_d = 1'b0;
            state_d    = ST_ACT;
            load_ids   = 1'b1;
          end else state_d = ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!is_cmd(state_d)) phase_d = PH_NONE;
    else if (state_d != state_q) phase_d = PH_REQ;
    if ((state_d == ST_FILL || state_d == ST_DRAIN) && state_d != state_q) col_d = '0;
  end

  // outputs are registered images of the next state so they line up with state_q
  always_comb begin
    wr_byte    = buf_out_d[DATA_WIDTH-1:0];
    cmd_req_d  = is_cmd(state_d) && (phase_d == PH_REQ);
    cmd_d      = cmd_q;
    case (state_d)
      ST_ACT:  cmd_d = CMD_ACT;
      ST_WR:   cmd_d = CMD_WR;
      ST_RD:   cmd_d = CMD_RD;
      ST_PRE:  cmd_d = CMD_PRE;
      default: cmd_d = cmd_q;
    endcase
    col_sel_d  = (state_d == ST_FILL || state_d == ST_DRAIN) ? (NUM_OF_COLS'(1) << col_d) : '0;
    buf_rw_d   = (state_d == ST_FILL);
    drv_en_d   = (state_d == ST_FILL);
    dout_d     = (state_d == ST_FILL) ? wr_byte[col_d] : 1'b0;
    bank_rw_d  = (state_d == ST_WR);
    bank_sel_d = load_ids ? (NUM_OF_BANKS'(1) << ld_bank) : bank_sel_q;
    row_sel_d  = load_ids ? (NUM_OF_ROWS'(1) << ld_row) : row_sel_q;
  end

  // all controller state, aborted immediately by reset
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_NONE;
      col_q      <= '0;
      buf_out_q  <= '0;
      rd_shift_q <= '0;
      rsp_q      <= '0;
      cmd_req_q  <= 1'b0;
      cmd_q      <= CMD_ACT;
      col_sel_q  <= '0;
      buf_rw_q   <= 1'b0;
      drv_en_q   <= 1'b0;
      dout_q     <= 1'b0;
      bank_rw_q  <= 1'b0;
      bank_sel_q <= '0;
      row_sel_q  <= '0;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
      open_q     <= 1'b0;
      pend_act_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      buf_out_q  <= buf_out_d;
      rd_shift_q <= rd_shift_d;
      rsp_q      <= rsp_d;
      cmd_req_q  <= cmd_req_d;
      cmd_q      <= cmd_d;
      col_sel_q  <= col_sel_d;
      buf_rw_q   <= buf_rw_d;
      drv_en_q   <= drv_en_d;
      dout_q     <= dout_d;
      bank_rw_q  <= bank_rw_d;
      bank_sel_q <= bank_sel_d;
      row_sel_q  <= row_sel_d;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
      open_q     <= open_d;
      pend_act_q <= pend_act_d;
`endif
    end
  end

  assign dram_data   = drv_en_q ? dout_q : 1'bz;
  assign cmd_req     = cmd_req_q;
  assign cmd         = cmd_q;
  assign bank_sel    = bank_sel_q;
  assign row_sel     = row_sel_q;
  assign col_sel     = col_sel_q;
  assign l2_rsp_data = rsp_q;
  assign bank_rw     = bank_rw_q;
  assign buf_rw      = buf_rw_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed vectors against dram_ctrl with a bank-array model and an ack responder.
// Latency: each isolated request is expected to produce ACT, WR/RD, PRE within a bounded cycle budget.
// Backpressure: cmd_ack can be withheld to stall the controller and fill the request FIFO.

module tb_dram_ctrl;
  localparam logic [1:0] C_ACT = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_PRE = 2'b11;

  logic         clk = 1'b0;
  logic         rst_b = 1'b1;
  logic         l2_rw_req = 1'b0;
  logic [21:0]  l2_req_instr = '0;
  logic [7:0]   l2_req_data = '0;
  logic         cmd_ack = 1'b0;
  wire          dram_data;
  logic         cmd_req;
  logic [1:0]   cmd;
  logic [7:0]   bank_sel;
  logic [127:0] row_sel;
  logic [7:0]   col_sel;
  logic [7:0]   l2_rsp_data;
  logic         bank_rw, buf_rw;

  int total = 0;
  int bad = 0;
  logic ack_en = 1'b1;

  // bank array model
  logic [7:0]   mem [0:1023];
  logic [7:0]   rowbuf = '0;
  logic [1:0]   cmd_log [$];
  logic [7:0]   act_bank;
  logic [127:0] act_row;
  logic [7:0]   fill_bits;
  int fill_n, drain_n, walk_err, dir_err, n_act, n_wr, n_rd, n_pre;
  logic req_prev = 1'b0;
  logic tb_drv, tb_bit;

  typedef struct {
    logic       rw;
    logic [2:0] bank;
    logic [6:0] row;
    logic [7:0] data;
    logic [7:0] exp_rsp;
  } vec_t;
  vec_t vecs [9];

  dram_ctrl dut (
    .clk(clk), .rst_b(rst_b), .l2_rw_req(l2_rw_req), .l2_req_instr(l2_req_instr),
    .l2_req_data(l2_req_data), .cmd_ack(cmd_ack), .dram_data(dram_data), .cmd_req(cmd_req),
    .cmd(cmd), .bank_sel(bank_sel), .row_sel(row_sel), .col_sel(col_sel),
    .l2_rsp_data(l2_rsp_data), .bank_rw(bank_rw), .buf_rw(buf_rw)
  );

  always #10 clk = ~clk;

  function automatic logic [2:0] idx8(input logic [7:0] v);
    logic [2:0] r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = i[2:0];
    return r;
  endfunction

  function automatic logic [6:0] idx128(input logic [127:0] v);
    logic [6:0] r = '0;
    for (int i = 0; i < 128; i++) if (v[i]) r = i[6:0];
    return r;
  endfunction

  assign tb_drv = !buf_rw && (col_sel != 8'h00);
  assign tb_bit = rowbuf[idx8(col_sel)];
  assign dram_data = tb_drv ? tb_bit : 1'bz;

  // ack responder: follows cmd_req 8 ns after each rising edge when enabled
  initial begin
    forever begin
      @(posedge clk);
      #8;
      cmd_ack = ack_en ? cmd_req : 1'b0;
    end
  end

  // command and serial-data monitor plus array behaviour
  initial begin
    logic [9:0] key;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_b) req_prev = 1'b0;
      else begin
        if (cmd_req && !req_prev) begin
          cmd_log.push_back(cmd);
          key = {idx8(bank_sel), idx128(row_sel)};
          if (cmd == C_ACT) begin n_act++; act_bank = bank_sel; act_row = row_sel; rowbuf = mem[key]; end
          if (cmd == C_WR) begin n_wr++; if (bank_rw) mem[key] = rowbuf; else dir_err++; end
          if (cmd == C_RD) begin n_rd++; if (bank_rw) dir_err++; end
          if (cmd == C_PRE) n_pre++;
        end
        req_prev = cmd_req;
        if (col_sel != 8'h00) begin
          if (buf_rw) begin
            rowbuf[idx8(col_sel)] = dram_data;
            if (fill_n < 8) begin
              fill_bits[fill_n[2:0]] = dram_data;
              if (col_sel != (8'd1 << fill_n[2:0])) walk_err++;
            end
            fill_n++;
          end else begin
            if (col_sel != (8'd1 << drain_n[2:0])) walk_err++;
            drain_n++;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    cmd_log.delete();
    fill_n = 0; drain_n = 0; walk_err = 0; dir_err = 0;
    n_act = 0; n_wr = 0; n_rd = 0; n_pre = 0; fill_bits = '0;
  endtask

  task automatic drive_req(input logic rw, input logic [2:0] b, input logic [6:0] r, input logic [7:0] d);
    // reserved bit, high address and column bits carry junk that must be ignored
    l2_rw_req    = rw;
    l2_req_instr = {1'b1, 1'b1, 7'h55, b, r, 3'b101};
    l2_req_data  = d;
  endtask

  task automatic send(input logic rw, input logic [2:0] b, input logic [6:0] r, input logic [7:0] d);
    tick();
    drive_req(rw, b, r, d);
    tick();
    l2_req_instr = '0;
  endtask

  task automatic wait_cmds(input string name, input int n, input int budget);
    int c = 0;
    while (cmd_log.size() < n && c < budget) begin tick(); c++; end
    check(name, 128'(cmd_log.size()), 128'(n));
    repeat (8) tick();
  endtask

  function automatic logic [11:0] log_word(input int n);
    logic [11:0] w = '0;
    for (int i = 0; i < n && i < 6; i++) if (i < cmd_log.size()) w[i*2 +: 2] = cmd_log[i];
    return w;
  endfunction

  initial begin
    int c;
    int hold_err;
    vecs[0] = '{1'b1, 3'd2, 7'd5,   8'hA5, 8'h00};
    vecs[1] = '{1'b0, 3'd2, 7'd5,   8'h00, 8'hA5};
    vecs[2] = '{1'b1, 3'd7, 7'd127, 8'h3C, 8'h00};
    vecs[3] = '{1'b1, 3'd0, 7'd0,   8'hFF, 8'h00};
    vecs[4] = '{1'b0, 3'd7, 7'd127, 8'h00, 8'h3C};
    vecs[5] = '{1'b0, 3'd0, 7'd0,   8'h00, 8'hFF};
    vecs[6] = '{1'b0, 3'd1, 7'd1,   8'h00, 8'h00};
    vecs[7] = '{1'b1, 3'd2, 7'd5,   8'h5A, 8'h00};
    vecs[8] = '{1'b0, 3'd2, 7'd5,   8'h00, 8'h5A};
    clear_mon();

    // reset values, held for two cycles
    repeat (2) tick();
    check("rst_cmd_req", 128'(cmd_req), 0);
    check("rst_outputs", {cmd, bank_sel, col_sel, l2_rsp_data, bank_rw, buf_rw}, 0);
    check("rst_row_sel", row_sel, 0);
    rst_b = 1'b0;
    repeat (4) tick();
    check("idle_no_cmd", 128'(n_act + int'(cmd_req)), 0);

    // table of isolated requests
    for (int v = 0; v < 9; v++) begin
      clear_mon();
      send(vecs[v].rw, vecs[v].bank, vecs[v].row, vecs[v].data);
      wait_cmds($sformatf("v%0d_done", v), 3, 300);
      check($sformatf("v%0d_seq", v), 128'(log_word(3)),
            128'({C_PRE, vecs[v].rw ? C_WR : C_RD, C_ACT}));
      check($sformatf("v%0d_bank", v), 128'(act_bank), 128'(8'd1 << vecs[v].bank));
      check($sformatf("v%0d_row", v), act_row, 128'd1 << vecs[v].row);
      check($sformatf("v%0d_walk", v), 128'(walk_err + dir_err), 0);
      if (vecs[v].rw) begin
        check($sformatf("v%0d_serial", v), 128'(fill_bits), 128'(vecs[v].data));
        check($sformatf("v%0d_nbits", v), 128'(fill_n), 8);
      end else begin
        check($sformatf("v%0d_rsp", v), 128'(l2_rsp_data), 128'(vecs[v].exp_rsp));
        check($sformatf("v%0d_nbits", v), 128'(drain_n), 8);
      end
      check($sformatf("v%0d_quiet", v), 128'({col_sel, buf_rw, bank_rw, cmd_req}), 0);
    end

    // stalled handshake: cmd_req and cmd must hold
    clear_mon();
    ack_en = 1'b0;
    send(1'b1, 3'd1, 7'd2, 8'h0F);
    c = 0;
    while (!cmd_req && c < 20) begin tick(); c++; end
    hold_err = 0;
    repeat (50) begin
      tick();
      if (!cmd_req || cmd != C_ACT) hold_err++;
    end
    check("hs_hold", 128'(hold_err), 0);
    ack_en = 1'b1;
    wait_cmds("hs_done", 3, 300);
    check("hs_seq", 128'(log_word(3)), 128'({C_PRE, C_WR, C_ACT}));

    // overflow: 64 back-to-back pushes while the first ACT is stalled
    clear_mon();
    ack_en = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      drive_req(1'b1, 3'd3, 7'd9, 8'($urandom_range(0, 255)));
    end
    tick();
    l2_req_instr = '0;
    check("ovf_first_act", 128'(n_act), 1);
    ack_en = 1'b1;
    c = 0;
    while (n_pre < 9 && c < 3000) begin tick(); c++; end
    repeat (100) tick();
    check("ovf_act", 128'(n_act), 9);
    check("ovf_wr", 128'(n_wr), 9);
    check("ovf_pre", 128'(n_pre), 9);

    // two writes to the same row, pushed back to back
    clear_mon();
    tick();
    drive_req(1'b1, 3'd6, 7'd33, 8'h11);
    tick();
    drive_req(1'b1, 3'd6, 7'd33, 8'h22);
    tick();
    l2_req_instr = '0;
`ifdef DRAM_CTRL_OPEN_PAGE_EN
    wait_cmds("pair_done", 4, 600);
    check("pair_seq", 128'(log_word(4)), 128'({C_PRE, C_WR, C_WR, C_ACT}));
`else
    wait_cmds("pair_done", 6, 600);
    check("pair_seq", 128'(log_word(6)), 128'({C_PRE, C_WR, C_ACT, C_PRE, C_WR, C_ACT}));
`endif
    clear_mon();
    send(1'b0, 3'd6, 7'd33, 8'h00);
    wait_cmds("pair_rd_done", 3, 300);
    check("pair_rd_rsp", 128'(l2_rsp_data), 128'(8'h22));

    // reset during a write fill aborts it and discards the queued request
    clear_mon();
    send(1'b1, 3'd4, 7'd4, 8'h81);
    send(1'b1, 3'd5, 7'd5, 8'h42);
    c = 0;
    while (fill_n < 3 && c < 100) begin tick(); c++; end
    check("mid_fill_reached", 128'(fill_n >= 3), 1);
    rst_b = 1'b1;
    tick();
    check("mid_rst_outputs", 128'({cmd_req, col_sel, buf_rw, bank_rw}), 0);
    rst_b = 1'b0;
    repeat (60) tick();
    check("mid_rst_no_replay", 128'(n_act), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
